// File: rtl/instr_mem_responder_if.sv
// Fetch-side request/response bundle for the instruction-memory responder.
// The master drives requests; the slave returns instruction words.
interface instr_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: returns the word at the requested PC after a fixed latency.
// A side-band load port fills the array at any time; the array is not cleared by reset.
module instr_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_mem_responder_if.slave  bus,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_W-1:0]     load_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic req_hit, load_hit;

  assign req_hit  = {1'b0, bus.req_addr} < DEPTH_A;
  assign load_hit = {1'b0, load_addr} < DEPTH_A;

  // Array has no reset so program contents survive a processor reset.
  always_ff @(posedge clk) begin
    if (load_en && load_hit)
      mem[load_addr[IDX_W-1:0]] <= load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Word is read from the pre-edge array, so a same-edge load is not forwarded.
          data_d  = req_hit ? mem[bus.req_addr[IDX_W-1:0]] : '0;
          err_d   = !req_hit;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder at LATENCY 2, 1 and 4.
// All three instances share stimulus; one is selected for observation at a time.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        rsp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  logic        busy_l2, busy_l1, busy_l4;
  int          sel = 0;
  int          checks = 0;
  int          failures = 0;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
  logic [31:0] o_rsp_data;

  always #5 clk = ~clk;

  instr_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) if_l2 ();
  instr_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) if_l1 ();
  instr_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) if_l4 ();

  assign if_l2.req_valid = req_valid;
  assign if_l2.req_addr  = req_addr;
  assign if_l2.rsp_ready = rsp_ready;
  assign if_l1.req_valid = req_valid;
  assign if_l1.req_addr  = req_addr;
  assign if_l1.rsp_ready = rsp_ready;
  assign if_l4.req_valid = req_valid;
  assign if_l4.req_addr  = req_addr;
  assign if_l4.rsp_ready = rsp_ready;

  instr_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .bus(if_l2.slave), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy_l2));
  instr_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .bus(if_l1.slave), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy_l1));
  instr_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .LATENCY(4)) dut_l4 (
    .clk(clk), .reset(reset), .bus(if_l4.slave), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy_l4));

  always_comb begin
    o_req_ready = if_l2.req_ready;
    o_rsp_valid = if_l2.rsp_valid;
    o_rsp_data  = if_l2.rsp_data;
    o_rsp_err   = if_l2.rsp_err;
    o_busy      = busy_l2;
    if (sel == 1) begin
      o_req_ready = if_l1.req_ready;
      o_rsp_valid = if_l1.rsp_valid;
      o_rsp_data  = if_l1.rsp_data;
      o_rsp_err   = if_l1.rsp_err;
      o_busy      = busy_l1;
    end else if (sel == 2) begin
      o_req_ready = if_l4.req_ready;
      o_rsp_valid = if_l4.rsp_valid;
      o_rsp_data  = if_l4.rsp_data;
      o_rsp_err   = if_l4.rsp_err;
      o_busy      = busy_l4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_program();
    load_word(8'd0, 32'h20010005);
    load_word(8'd1, 32'h20020003);
    load_word(8'd2, 32'h00221820);
    load_word(8'd3, 32'h08000000);
  endtask

  // n counts cycles since the acceptance cycle; the acceptance edge has already passed.
  task automatic wait_rsp(input int n0, input int lat, input logic [31:0] exp_d,
                          input logic exp_e, input string nm);
    int n;
    n = n0;
    while (o_rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== lat) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles want %0d", nm, n, lat);
    end
    checks++;
    if (o_rsp_data !== exp_d) begin
      failures++;
      $display("FAIL %s rsp_data: got %h want %h", nm, o_rsp_data, exp_d);
    end
    checks++;
    if (o_rsp_err !== exp_e) begin
      failures++;
      $display("FAIL %s rsp_err: got %b want %b", nm, o_rsp_err, exp_e);
    end
  endtask

  task automatic issue_and_wait(input logic [7:0] a, input int lat, input logic [31:0] exp_d,
                                input logic exp_e, input string nm);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: busy=%b req_ready=%b want busy=1 req_ready=0", nm, o_busy, o_req_ready);
    end
    wait_rsp(1, lat, exp_d, exp_e, nm);
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: req_ready=%b rsp_valid=%b busy=%b want 1 0 0",
               nm, o_req_ready, o_rsp_valid, o_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    check_idle("reset");
    checks++;
    if (o_rsp_data !== 32'h0 || o_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: rsp_data=%h rsp_err=%b want 00000000 0", o_rsp_data, o_rsp_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic(input int lat);
    rsp_ready = 1'b1;
    issue_and_wait(8'd2, lat, 32'h00221820, 1'b0, "basic");
    tick();
    check_idle("basic_done");
  endtask

  task automatic test_hold(input int lat);
    rsp_ready = 1'b0;
    issue_and_wait(8'd1, lat, 32'h20020003, 1'b0, "hold");
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h20020003 || o_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle %0d: rsp_valid=%b rsp_data=%h req_ready=%b want 1 20020003 0",
                 i, o_rsp_valid, o_rsp_data, o_req_ready);
      end
    end
    rsp_ready = 1'b1;
    tick();
    check_idle("hold_release");
  endtask

  task automatic test_out_of_range();
    rsp_ready = 1'b1;
    issue_and_wait(8'd20, 2, 32'h0, 1'b1, "oor_req");
    tick();
    check_idle("oor_done");
    // Address 20 would alias to word 4 if the range check were missing.
    load_word(8'd20, 32'hDEADBEEF);
    issue_and_wait(8'd4, 2, 32'h00000044, 1'b0, "oor_load");
    tick();
  endtask

  task automatic test_load_during_wait();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd0;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 8'd0; load_data = 32'hFFFFFFFF;
    tick();
    load_en = 1'b0;
    wait_rsp(2, 2, 32'h20010005, 1'b0, "load_in_wait");
    tick();
    issue_and_wait(8'd0, 2, 32'hFFFFFFFF, 1'b0, "load_in_wait_next");
    tick();
    req_valid = 1'b1; req_addr = 8'd1;
    load_en = 1'b1; load_addr = 8'd1; load_data = 32'h11111111;
    tick();
    req_valid = 1'b0; load_en = 1'b0;
    wait_rsp(1, 2, 32'h20020003, 1'b0, "same_edge_load");
    tick();
    issue_and_wait(8'd1, 2, 32'h11111111, 1'b0, "same_edge_next");
    tick();
  endtask

  task automatic test_reset_in_wait();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd2;
    tick();
    req_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_wait setup: busy=%b want 1", o_busy);
    end
    reset = 1'b1;
    #1;
    check_idle("reset_in_wait_async");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("reset_in_wait_after");
    end
    issue_and_wait(8'd2, 2, 32'h00221820, 1'b0, "reset_keeps_mem");
    tick();
  endtask

  task automatic test_back_to_back(input int lat);
    int n;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd3;
    n = 0;
    while (o_rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tick();
    n = 1;
    while (o_rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== lat + 1 || o_rsp_data !== 32'h08000000) begin
      failures++;
      $display("FAIL back_to_back: spacing %0d data %h want %0d 08000000", n, o_rsp_data, lat + 1);
    end
    req_valid = 1'b0;
    n = 0;
    while (o_busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check_idle("back_to_back_drain");
  endtask

  task automatic test_stream(input int lat);
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      load_word(8'(i), {16'hC0DE, 16'(i * 3 + 1)});
    for (int i = 0; i < 12; i++) begin
      issue_and_wait(8'(i), lat, {16'hC0DE, 16'(i * 3 + 1)}, 1'b0, "stream");
      tick();
    end
    check_idle("stream_done");
  endtask

  initial begin
    sel = 0;
    test_reset();
    load_program();
    load_word(8'd4, 32'h00000044);
    test_basic(2);
    test_hold(2);
    test_out_of_range();
    test_load_during_wait();
    load_program();
    test_reset_in_wait();
    test_back_to_back(2);
    test_stream(2);

    sel = 1;
    test_reset();
    load_program();
    test_basic(1);
    test_hold(1);
    test_back_to_back(1);
    test_stream(1);

    sel = 2;
    test_reset();
    load_program();
    test_basic(4);
    test_hold(4);
    test_back_to_back(4);
    test_stream(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
